mem_load_controller: RTL

MEM_LOAD_CONTROLLER -- requirements
Module: mem_load_controller

---
 rtl/mem_load_controller_pkg.sv | 16 +
 rtl/mem_load_controller_addr_counter.sv | 42 ++++
 rtl/mem_load_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_load_controller_pkg.sv
// Shared widths and FSM encoding for the burst memory load controller.
package mem_load_controller_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned SECT_W    = 4;
    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned COUNT_W   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_load_controller_addr_counter.sv
// Linear {sector,address} write pointer: load, increment, wraps at the top of the space.
module mem_addr_counter #(
    parameter int unsigned SECT_W = mem_load_controller_pkg::SECT_W,
    parameter int unsigned ADDR_W = mem_load_controller_pkg::ADDR_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              incr_i,
    input  logic [SECT_W-1:0] load_sector_i,
    input  logic [ADDR_W-1:0] load_address_i,
    output logic [SECT_W-1:0] sector_o,
    output logic [ADDR_W-1:0] address_o
);

    localparam int unsigned PTR_W = SECT_W + ADDR_W;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Load has priority; natural overflow gives the {max,max} -> {0,0} wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = {load_sector_i, load_address_i};
        end else if (incr_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign sector_o  = ptr_q[PTR_W-1 -: SECT_W];
    assign address_o = ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/mem_load_controller.sv
// Streams in_data words into sectored memory as a counted burst, one registered write per accepted word.
module mem_load_controller #(
    parameter int unsigned DATA_W = mem_load_controller_pkg::DATA_W,
    parameter int unsigned ADDR_W = mem_load_controller_pkg::ADDR_W,
    parameter int unsigned SECT_W = mem_load_controller_pkg::SECT_W
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [SECT_W-1:0]                        start_sector,
    input  logic [ADDR_W-1:0]                        start_address,
    input  logic [mem_load_controller_pkg::COUNT_W-1:0] word_count,
    input  logic                                     abort,
    input  logic [DATA_W-1:0]                        in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [DATA_W-1:0]                        data_write,
    output logic [SECT_W-1:0]                        sector_write_select,
    output logic [ADDR_W-1:0]                        write_address,
    output logic                                     write_enable,
    output logic                                     busy,
    output logic                                     done
);

    import mem_load_controller_pkg::*;

    state_e             state_q;
    state_e             state_d;
    logic [COUNT_W-1:0] remaining_q;
    logic [COUNT_W-1:0] remaining_d;

    logic               accept_c;
    logic               ptr_load_c;
    logic [SECT_W-1:0]  ptr_sector;
    logic [ADDR_W-1:0]  ptr_address;

    logic [DATA_W-1:0]  data_write_q;
    logic [SECT_W-1:0]  sector_write_select_q;
    logic [ADDR_W-1:0]  write_address_q;
    logic               write_enable_q;
    logic               busy_q;
    logic               done_q;

    assign in_ready = (state_q == LOAD) && !abort;
    assign accept_c = in_valid && in_ready;

    mem_addr_counter #(
        .SECT_W (SECT_W),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clock_i        (clock),
        .reset_i        (reset),
        .load_i         (ptr_load_c),
        .incr_i         (accept_c),
        .load_sector_i  (start_sector),
        .load_address_i (start_address),
        .sector_o       (ptr_sector),
        .address_o      (ptr_address)
    );

    // Next-state and burst length bookkeeping; a zero count means a full-space burst.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ptr_load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    ptr_load_c  = 1'b1;
                    remaining_d = (word_count == '0) ? COUNT_W'(MEM_WORDS) : word_count;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (accept_c) begin
                    remaining_d = remaining_q - COUNT_W'(1);
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            write_enable_q <= accept_c;
            busy_q         <= (state_d == LOAD);
            done_q         <= (state_d == DONE);
        end
    end

    // Write payload holds its last value between accepts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_write_q          <= '0;
            sector_write_select_q <= '0;
            write_address_q       <= '0;
        end else if (accept_c) begin
            data_write_q          <= in_data;
            sector_write_select_q <= ptr_sector;
            write_address_q       <= ptr_address;
        end
    end

    assign data_write          = data_write_q;
    assign sector_write_select = sector_write_select_q;
    assign write_address       = write_address_q;
    assign write_enable        = write_enable_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule
